rom_port_arbiter: RTL and testbench
===================================

Name: rom_port_arbiter

Overview:
Parametrised ROM access hub for arcade cores. It shares one SDRAM-style memory port among CHANNELS byte-wide CPU/video read channels using round-robin arbitration, and routes data_io download bytes into the same port. It tracks download completion to produce rom_loaded and the core reset. It sits between the data_io/sdram instances and the core's ROM fetch logic.

Parameters:
CHANNELS, 2, number of read channels (1..8)
AW, 15, per-channel byte address width
MAW, 24, memory byte address width
BASES, {24'h008000, 24'h000000}, CHANNELS*MAW bits; channel i base offset in bits [i*MAW +: MAW]

Ports:
clk_sys  in  1  system clock
reset  in  1  asynchronous, active-high
ext_reset  in  1  synchronous core reset request (OSD/button)
ch_req  in  CHANNELS  per-channel read request, level, held until ack
ch_addr  in  CHANNELS*AW  per-channel byte address, stable while ch_req high
ch_ack  out  CHANNELS  one-cycle ack; ch_dout valid from the same cycle
ch_dout  out  CHANNELS*8  per-channel data, held until that channel's next ack
dl_active  in  1  download in progress
dl_wr  in  1  download byte strobe
dl_addr  in  MAW  download byte address
dl_data  in  8  download byte
mem_addr  out  MAW  memory byte address
mem_din  out  16  write data, {dl_data, dl_data}
mem_rd  out  1  one-cycle read strobe
mem_we  out  1  one-cycle write strobe
mem_ready  in  1  one-cycle completion pulse; mem_dout valid on it for reads
mem_dout  in  16  read data
rom_loaded  out  1  sticky: download has completed
core_reset  out  1  reset to core
dl_overrun  out  1  sticky error flag

Behaviour:
- Reset values: ch_ack=0, ch_dout=0, mem_rd=0, mem_we=0, mem_addr=0, rom_loaded=0, core_reset=1, dl_overrun=0, state IDLE, RR pointer=CHANNELS-1.
- States: IDLE, RD_WAIT, WR_WAIT.
- IDLE, dl_active=1: on dl_wr, register addr/data, mem_we=1 for exactly one cycle, go WR_WAIT. Channel requests are not granted; they stall without ack.
- IDLE, dl_active=0: grant the first requesting channel searching from pointer+1, wrapping modulo CHANNELS. mem_addr = BASES[i] + zero-extended ch_addr[i], truncated to MAW bits (wraps). mem_rd=1 for one cycle. Pointer := i. Go RD_WAIT.
- RD_WAIT: on mem_ready, ch_dout[i] = mem_dout[7:0] if byte address bit0=0, else mem_dout[15:8]. Same cycle: ch_ack[i]=1 and return to IDLE.
- WR_WAIT: on mem_ready, return to IDLE.
- Latency: request present in IDLE at cycle 0 -> mem_rd at cycle 1 -> ack one cycle after mem_ready is sampled. New grant is possible the cycle after ack.
- The requester must drop ch_req in the cycle after ack or it is re-queued.
- dl_wr while in WR_WAIT or RD_WAIT: byte is dropped and dl_overrun set (sticky until reset).
- dl_active rising during RD_WAIT: the read completes and is acked; downloads start from IDLE.
- rom_loaded: set on dl_active falling edge (registered prev value 1, current 0); cleared only by reset.
- core_reset: registered = ext_reset | ~rom_loaded | dl_active.
- Asynchronous reset mid-transaction aborts; any pending mem_ready after reset is ignored in IDLE.

Optional Feature:
ARB_WORD_CACHE_EN: each channel keeps the last fetched 16-bit word, its word address (mem byte address bits [MAW-1:1]), and a valid bit. A request in IDLE whose word address matches a valid entry is acked one cycle later from the cache, with no mem_rd and no change to the RR pointer. Hits take priority over misses from other channels. All valid bits are cleared on reset and whenever dl_active=1. Without the macro, every request issues mem_rd.

Test Plan:
- Reset, no download -> rom_loaded=0, core_reset=1. Pulse dl_active for 100 cycles -> rom_loaded=1 and core_reset=0 two cycles after the fall.
- Download: dl_wr with addr 0x000010, data 0xA5 -> single mem_we, mem_addr=0x000010, mem_din=0xA5A5. Second dl_wr before mem_ready -> dl_overrun=1, no second mem_we.
- Channel 1 read of ch_addr 0x0003, mem_dout=0x1234 -> mem_addr=0x000003, ch_dout[1]=0x12, ch_ack[1] pulses once.
- Both channels requesting continuously -> grants alternate 0,1,0,1 with no channel granted twice in a row.
- Channel 0 base 0xFFFFF0, ch_addr 0x0020 -> mem_addr=0x000010 (wrap).
- With ARB_WORD_CACHE_EN: channel 0 reads 0x0004 then 0x0005 -> one mem_rd total, second ack has no mem_rd. Without the macro -> two mem_rd.

Source files
------------

// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter
// Shares one SDRAM-style memory port between CHANNELS byte-wide read channels
// (round-robin) and the data_io download stream. It also tracks download
// completion to produce rom_loaded and the core reset.
//
// Ports:
//   clk_sys, reset          clock, asynchronous active-high reset
//   ext_reset               core reset request (OSD/button)
//   ch_req/ch_addr          per-channel read request (level) and byte address
//   ch_ack/ch_dout          one-cycle ack, data held until the channel's next ack
//   dl_active/dl_wr/dl_addr/dl_data   download stream from data_io
//   mem_addr/mem_din/mem_rd/mem_we    memory command (one-cycle strobes)
//   mem_ready/mem_dout      memory completion pulse and read data
//   rom_loaded              sticky: a download has completed
//   core_reset              reset to the core
//   dl_overrun              sticky: a download byte arrived while the port was busy
//
// Optional build macro ARB_WORD_CACHE_EN: a per-channel one-word cache serves
// requests that hit the last fetched word without touching the memory port.
module rom_port_arbiter #(
    parameter int                        CHANNELS = 2,
    parameter int                        AW       = 15,
    parameter int                        MAW      = 24,
    parameter logic [CHANNELS*MAW-1:0]   BASES    = {24'h008000, 24'h000000}
) (
    input  logic                     clk_sys,
    input  logic                     reset,
    input  logic                     ext_reset,
    input  logic [CHANNELS-1:0]      ch_req,
    input  logic [CHANNELS*AW-1:0]   ch_addr,
    output logic [CHANNELS-1:0]      ch_ack,
    output logic [CHANNELS*8-1:0]    ch_dout,
    input  logic                     dl_active,
    input  logic                     dl_wr,
    input  logic [MAW-1:0]           dl_addr,
    input  logic [7:0]               dl_data,
    output logic [MAW-1:0]           mem_addr,
    output logic [15:0]              mem_din,
    output logic                     mem_rd,
    output logic                     mem_we,
    input  logic                     mem_ready,
    input  logic [15:0]              mem_dout,
    output logic                     rom_loaded,
    output logic                     core_reset,
    output logic                     dl_overrun
);

    localparam int              CW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [CW:0]     NCH = (CW+1)'(CHANNELS);

    typedef enum logic [1:0] {IDLE = 2'd0, RD_WAIT = 2'd1, WR_WAIT = 2'd2} state_t;

    state_t                  state_q;
    logic [CW-1:0]           ptr_q;
    logic [CHANNELS-1:0]     ch_ack_q;
    logic [CHANNELS*8-1:0]   ch_dout_q;
    logic [MAW-1:0]          mem_addr_q;
    logic [15:0]             mem_din_q;
    logic                    mem_rd_q;
    logic                    mem_we_q;
    logic                    dl_prev_q;
    logic                    rom_loaded_q;
    logic                    core_reset_q;
    logic                    dl_overrun_q;

    function automatic logic [7:0] pick_byte(input logic [15:0] w, input logic odd);
        return odd ? w[15:8] : w[7:0];
    endfunction

    // Memory byte address of each channel's current request (wraps at MAW bits).
    logic [MAW-1:0] ch_maddr [CHANNELS];
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            ch_maddr[i] = BASES[i*MAW +: MAW] + MAW'(ch_addr[i*AW +: AW]);
        end
    end

    // Round-robin search starting just after the last granted channel.
    logic           gnt_vld;
    logic [CW-1:0]  gnt_idx;
    logic [CW:0]    cand;
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = ptr_q;
        cand    = '0;
        for (int k = 1; k <= CHANNELS; k++) begin
            cand = {1'b0, ptr_q} + (CW+1)'(k);
            if (cand >= NCH) cand = cand - NCH;
            if (!gnt_vld && ch_req[cand[CW-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand[CW-1:0];
            end
        end
    end

`ifdef ARB_WORD_CACHE_EN
    logic [15:0]         cw_q   [CHANNELS];
    logic [MAW-2:0]      ctag_q [CHANNELS];
    logic [CHANNELS-1:0] cval_q;
    logic                rd_done;
    logic                hit_vld;
    logic [CW-1:0]       hit_idx;

    assign rd_done = (state_q == RD_WAIT) && mem_ready;

    // Lowest-numbered hitting channel wins; hits never move the RR pointer.
    always_comb begin
        hit_vld = 1'b0;
        hit_idx = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (ch_req[i] && cval_q[i] && (ctag_q[i] == ch_maddr[i][MAW-1:1])) begin
                hit_vld = 1'b1;
                hit_idx = CW'(i);
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rd_done) begin
            cw_q[ptr_q]   <= mem_dout;
            ctag_q[ptr_q] <= mem_addr_q[MAW-1:1];
        end
    end

    // A download may rewrite any word, so the cache is flushed while it runs.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset)          cval_q <= '0;
        else if (dl_active) cval_q <= '0;
        else if (rd_done)   cval_q[ptr_q] <= 1'b1;
    end
`endif

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            ptr_q        <= CW'(CHANNELS - 1);
            ch_ack_q     <= '0;
            ch_dout_q    <= '0;
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
            mem_rd_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            dl_prev_q    <= 1'b0;
            rom_loaded_q <= 1'b0;
            core_reset_q <= 1'b1;
            dl_overrun_q <= 1'b0;
        end else begin
            ch_ack_q     <= '0;
            mem_rd_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            dl_prev_q    <= dl_active;
            if (dl_prev_q && !dl_active) rom_loaded_q <= 1'b1;
            core_reset_q <= ext_reset | ~rom_loaded_q | dl_active;

            case (state_q)
                IDLE: begin
                    if (dl_active) begin
                        if (dl_wr) begin
                            mem_addr_q <= dl_addr;
                            mem_din_q  <= {dl_data, dl_data};
                            mem_we_q   <= 1'b1;
                            state_q    <= WR_WAIT;
                        end
                    // No grant during an ack cycle: the acked requester still
                    // holds ch_req and only drops it in the following cycle.
                    end else if (ch_ack_q == '0) begin
`ifdef ARB_WORD_CACHE_EN
                        if (hit_vld) begin
                            ch_ack_q[hit_idx] <= 1'b1;
                            ch_dout_q[int'(hit_idx)*8 +: 8] <=
                                pick_byte(cw_q[hit_idx], ch_maddr[hit_idx][0]);
                        end else
`endif
                        if (gnt_vld) begin
                            mem_addr_q <= ch_maddr[gnt_idx];
                            mem_rd_q   <= 1'b1;
                            ptr_q      <= gnt_idx;
                            state_q    <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    if (dl_wr) dl_overrun_q <= 1'b1;
                    if (mem_ready) begin
                        ch_ack_q[ptr_q] <= 1'b1;
                        ch_dout_q[int'(ptr_q)*8 +: 8] <= pick_byte(mem_dout, mem_addr_q[0]);
                        state_q <= IDLE;
                    end
                end
                WR_WAIT: begin
                    if (dl_wr) dl_overrun_q <= 1'b1;
                    if (mem_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ch_ack     = ch_ack_q;
    assign ch_dout    = ch_dout_q;
    assign mem_addr   = mem_addr_q;
    assign mem_din    = mem_din_q;
    assign mem_rd     = mem_rd_q;
    assign mem_we     = mem_we_q;
    assign rom_loaded = rom_loaded_q;
    assign core_reset = core_reset_q;
    assign dl_overrun = dl_overrun_q;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Testbench for rom_port_arbiter: directed stimulus, expected memory commands
// and channel data queued by the stimulus and checked by a separate monitor.
module tb_rom_port_arbiter;

    localparam int CHANNELS = 2;
    localparam int AW       = 15;
    localparam int MAW      = 24;

    logic                   clk_sys = 1'b0;
    logic                   reset;
    logic                   ext_reset;
    logic [CHANNELS-1:0]    ch_req;
    logic [CHANNELS*AW-1:0] ch_addr;
    logic [CHANNELS-1:0]    ch_ack;
    logic [CHANNELS*8-1:0]  ch_dout;
    logic                   dl_active;
    logic                   dl_wr;
    logic [MAW-1:0]         dl_addr;
    logic [7:0]             dl_data;
    logic [MAW-1:0]         mem_addr;
    logic [15:0]            mem_din;
    logic                   mem_rd;
    logic                   mem_we;
    logic                   mem_ready;
    logic [15:0]            mem_dout;
    logic                   rom_loaded;
    logic                   core_reset;
    logic                   dl_overrun;

    logic          req0, req1;
    logic [AW-1:0] addr0, addr1;
    assign ch_req  = {req1, req0};
    assign ch_addr = {addr1, addr0};

    always #5 clk_sys = ~clk_sys;

    // Channel 1 base 0, channel 0 base 0xFFFFF0 (exercises address wrap).
    rom_port_arbiter #(
        .CHANNELS(CHANNELS), .AW(AW), .MAW(MAW),
        .BASES({24'h000000, 24'hFFFFF0})
    ) dut (
        .clk_sys(clk_sys), .reset(reset), .ext_reset(ext_reset),
        .ch_req(ch_req), .ch_addr(ch_addr), .ch_ack(ch_ack), .ch_dout(ch_dout),
        .dl_active(dl_active), .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_rd(mem_rd), .mem_we(mem_we),
        .mem_ready(mem_ready), .mem_dout(mem_dout),
        .rom_loaded(rom_loaded), .core_reset(core_reset), .dl_overrun(dl_overrun)
    );

    typedef struct packed {
        logic        we;
        logic [23:0] addr;
        logic [15:0] din;
    } memop_t;

    memop_t     exp_mem[$];
    logic [7:0] exp_ack0[$];
    logic [7:0] exp_ack1[$];
    int tests = 0, fails = 0;
    int rd_cnt = 0, we_cnt = 0, ack_cnt0 = 0, ack_cnt1 = 0;
    int lat = 2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compares every memory command and every ack against the queues.
    initial begin
        memop_t     e;
        logic [7:0] d;
        forever begin
            @(negedge clk_sys);
            if (!reset) begin
                if (mem_rd || mem_we) begin
                    if (mem_rd) rd_cnt++;
                    if (mem_we) we_cnt++;
                    if (exp_mem.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_mem_op: actual rd=%0b we=%0b addr=0x%h required=no op",
                                 mem_rd, mem_we, mem_addr);
                    end else begin
                        e = exp_mem.pop_front();
                        check("mem_we", 32'(mem_we), 32'(e.we));
                        check("mem_rd", 32'(mem_rd), 32'(!e.we));
                        check("mem_addr", 32'(mem_addr), 32'(e.addr));
                        if (e.we) check("mem_din", 32'(mem_din), 32'(e.din));
                    end
                end
                if (ch_ack[0]) begin
                    ack_cnt0++;
                    if (exp_ack0.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_ack0: actual=ack required=none");
                    end else begin
                        d = exp_ack0.pop_front();
                        check("ch0_dout", 32'(ch_dout[7:0]), 32'(d));
                    end
                end
                if (ch_ack[1]) begin
                    ack_cnt1++;
                    if (exp_ack1.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_ack1: actual=ack required=none");
                    end else begin
                        d = exp_ack1.pop_front();
                        check("ch1_dout", 32'(ch_dout[15:8]), 32'(d));
                    end
                end
            end
        end
    end

    // Memory model: word at word address 1 is 0x1234, otherwise {~lo, lo}
    // with lo = low address byte with bit0 cleared.
    initial begin
        logic [23:0] a;
        logic [7:0]  lo;
        logic [15:0] w;
        mem_ready = 1'b0;
        mem_dout  = '0;
        forever begin
            @(negedge clk_sys);
            if (!reset && (mem_rd || mem_we)) begin
                a  = mem_addr;
                lo = {a[7:1], 1'b0};
                if (a[23:1] == 23'h1) w = 16'h1234;
                else                  w = {~lo, lo};
                repeat (lat) @(negedge clk_sys);
                mem_dout  = w;
                mem_ready = 1'b1;
                @(negedge clk_sys);
                mem_ready = 1'b0;
            end
        end
    end

    task automatic do_read(input int ch, input logic [AW-1:0] a);
        int n;
        @(negedge clk_sys);
        if (ch == 0) begin addr0 = a; req0 = 1'b1; end
        else         begin addr1 = a; req1 = 1'b1; end
        n = 0;
        do begin
            @(negedge clk_sys);
            n++;
        end while (!ch_ack[ch] && n < 60);
        if (!ch_ack[ch]) begin
            tests++; fails++;
            $display("FAIL ack_timeout_ch%0d: actual=no ack required=ack within 60 cycles", ch);
        end
        if (ch == 0) req0 = 1'b0; else req1 = 1'b0;
        @(negedge clk_sys);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int rd0;
        reset = 1'b1; ext_reset = 1'b0;
        req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
        dl_active = 1'b0; dl_wr = 1'b0; dl_addr = '0; dl_data = '0;
        repeat (3) @(negedge clk_sys);

        // Reset values
        check("rst_rom_loaded", 32'(rom_loaded), 32'(0));
        check("rst_core_reset", 32'(core_reset), 32'(1));
        check("rst_mem_rd", 32'(mem_rd), 32'(0));
        check("rst_mem_we", 32'(mem_we), 32'(0));
        check("rst_mem_addr", 32'(mem_addr), 32'(0));
        check("rst_ch_ack", 32'(ch_ack), 32'(0));
        check("rst_ch_dout", 32'(ch_dout), 32'(0));
        check("rst_dl_overrun", 32'(dl_overrun), 32'(0));
        reset = 1'b0;
        repeat (2) @(negedge clk_sys);
        check("no_dl_core_reset", 32'(core_reset), 32'(1));

        // Download: one write, then a second byte while the write is pending
        dl_active = 1'b1;
        repeat (3) @(negedge clk_sys);
        exp_mem.push_back('{we: 1'b1, addr: 24'h000010, din: 16'hA5A5});
        dl_wr = 1'b1; dl_addr = 24'h000010; dl_data = 8'hA5;
        @(negedge clk_sys);
        dl_addr = 24'h000011; dl_data = 8'h5A;
        @(negedge clk_sys);
        dl_wr = 1'b0;
        repeat (8) @(negedge clk_sys);
        check("dl_overrun_set", 32'(dl_overrun), 32'(1));
        check("dl_single_we", 32'(we_cnt), 32'(1));
        repeat (85) @(negedge clk_sys);
        check("dl_core_reset", 32'(core_reset), 32'(1));
        check("dl_rom_loaded", 32'(rom_loaded), 32'(0));
        dl_active = 1'b0;
        @(negedge clk_sys);
        check("fall1_rom_loaded", 32'(rom_loaded), 32'(1));
        check("fall1_core_reset", 32'(core_reset), 32'(1));
        @(negedge clk_sys);
        check("fall2_core_reset", 32'(core_reset), 32'(0));

        // ext_reset forces the core reset
        ext_reset = 1'b1;
        @(negedge clk_sys);
        check("ext_core_reset", 32'(core_reset), 32'(1));
        ext_reset = 1'b0;
        @(negedge clk_sys);
        check("ext_release", 32'(core_reset), 32'(0));

        // Channel 1 read of 0x0003 -> mem 0x000003, odd byte of 0x1234
        exp_mem.push_back('{we: 1'b0, addr: 24'h000003, din: 16'h0});
        exp_ack1.push_back(8'h12);
        addr1 = 15'h0003; req1 = 1'b1;
        @(negedge clk_sys);
        check("rd_latency", 32'(mem_rd), 32'(1));
        n = 0;
        do begin
            @(negedge clk_sys);
            n++;
        end while (!ch_ack[1] && n < 60);
        check("ack_latency", 32'(n), 32'(lat + 1));
        req1 = 1'b0;
        @(negedge clk_sys);
        check("ack_one_pulse", 32'(ch_ack), 32'(0));
        check("dout_held", 32'(ch_dout[15:8]), 32'(8'h12));
        repeat (3) @(negedge clk_sys);
        check("ack1_count", 32'(ack_cnt1), 32'(1));

        // Channel 0 base 0xFFFFF0 + 0x20 wraps to 0x000010
        exp_mem.push_back('{we: 1'b0, addr: 24'h000010, din: 16'h0});
        exp_ack0.push_back(8'h10);
        do_read(0, 15'h0020);

        // Both channels busy: grants alternate, ch1 first (pointer is 0)
        exp_mem.push_back('{we: 1'b0, addr: 24'h000100, din: 16'h0});
        exp_mem.push_back('{we: 1'b0, addr: 24'h000030, din: 16'h0});
        exp_mem.push_back('{we: 1'b0, addr: 24'h000102, din: 16'h0});
        exp_mem.push_back('{we: 1'b0, addr: 24'h000032, din: 16'h0});
        exp_mem.push_back('{we: 1'b0, addr: 24'h000104, din: 16'h0});
        exp_mem.push_back('{we: 1'b0, addr: 24'h000034, din: 16'h0});
        exp_ack1.push_back(8'h00); exp_ack1.push_back(8'h02); exp_ack1.push_back(8'h04);
        exp_ack0.push_back(8'h30); exp_ack0.push_back(8'h32); exp_ack0.push_back(8'h34);
        fork
            begin
                do_read(0, 15'h0040); do_read(0, 15'h0042); do_read(0, 15'h0044);
            end
            begin
                do_read(1, 15'h0100); do_read(1, 15'h0102); do_read(1, 15'h0104);
            end
        join

        // Same-word pair on channel 0: 0x0004 then 0x0005 (mem 0xFFFFF4/5)
        rd0 = rd_cnt;
        exp_mem.push_back('{we: 1'b0, addr: 24'hFFFFF4, din: 16'h0});
`ifndef ARB_WORD_CACHE_EN
        exp_mem.push_back('{we: 1'b0, addr: 24'hFFFFF5, din: 16'h0});
`endif
        exp_ack0.push_back(8'hF4);
        exp_ack0.push_back(8'h0B);
        do_read(0, 15'h0004);
        do_read(0, 15'h0005);
`ifdef ARB_WORD_CACHE_EN
        check("cache_rd_count", 32'(rd_cnt - rd0), 32'(1));
`else
        check("nocache_rd_count", 32'(rd_cnt - rd0), 32'(2));
`endif

        repeat (5) @(negedge clk_sys);
        check("overrun_sticky", 32'(dl_overrun), 32'(1));
        check("rom_loaded_sticky", 32'(rom_loaded), 32'(1));
        check("exp_mem_drained", 32'(exp_mem.size()), 32'(0));
        check("exp_ack0_drained", 32'(exp_ack0.size()), 32'(0));
        check("exp_ack1_drained", 32'(exp_ack1.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
